// File: rtl/mem_port_arbiter_pkg.sv
// Shared LC-3b memory-side types: line/address widths and the port arbiter state encoding.
package lc3b_types;

    localparam int LC3B_ADDR_W = 12;
    localparam int LC3B_LINE_W = 128;
    localparam int LC3B_SEL_W  = 16;

    typedef logic [LC3B_LINE_W-1:0] lc3b_line;
    typedef logic [LC3B_ADDR_W-1:0] lc3b_wb_adr;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } lc3b_arb_state;

endpackage

// File: rtl/mem_port_arbiter_grant_select.sv
// Grant choice for one idle-cycle arbitration. MEM_ARB_ROUND_ROBIN_EN alternates on collisions;
// otherwise data always beats instruction.
module arb_grant_select (
    input  logic i_req,
    input  logic d_req,
    input  logic last_owner,
    output logic grant_i,
    output logic grant_d_next
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    // last_owner = 1 means data owned the previous transaction, so a collision goes to instruction.
    always_comb begin
        grant_d_next = d_req & ~(i_req & RR_EN & last_owner);
        grant_i      = i_req & ~grant_d_next;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (ifetch, data) arbiter in front of one line-granular memory port.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin collision resolution.
module mem_port_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = LC3B_ADDR_W,
    parameter int LINE_W = LC3B_LINE_W,
    parameter int SEL_W  = LC3B_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    input  logic [SEL_W-1:0]  d_sel,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [LINE_W-1:0] m_wdata,
    output logic [SEL_W-1:0]  m_sel,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp,
    output logic              grant_d
);

    lc3b_arb_state state, state_next;

    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;
    logic [SEL_W-1:0]  lat_sel;
    logic              lat_write;

    logic d_req;
    logic grant_i;
    logic grant_d_next;
    logic last_owner;

    assign d_req = d_read | d_write;

    arb_grant_select u_grant (
        .i_req        (i_read),
        .d_req        (d_req),
        .last_owner   (last_owner),
        .grant_i      (grant_i),
        .grant_d_next (grant_d_next)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= 1'b1;
        end else if (state == IDLE && (grant_d_next || grant_i)) begin
            last_owner <= grant_d_next;
        end
    end
`else
    assign last_owner = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request is captured on the same edge that grants it; later upstream changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_sel   <= '0;
            lat_write <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_d_next) begin
                lat_addr  <= d_address;
                lat_wdata <= d_wdata;
                lat_sel   <= d_sel;
                lat_write <= d_write;
            end else if (grant_i) begin
                lat_addr  <= i_address;
                lat_write <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        m_read     = 1'b0;
        m_write    = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d_next) begin
                    state_next = SERVE_D;
                end else if (grant_i) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I: begin
                m_read  = ~lat_write;
                m_write = lat_write;
                if (m_resp) begin
                    i_resp     = 1'b1;
                    state_next = RECOVER;
                end
            end
            SERVE_D: begin
                grant_d = 1'b1;
                m_read  = ~lat_write;
                m_write = lat_write;
                if (m_resp) begin
                    d_resp     = 1'b1;
                    state_next = RECOVER;
                end
            end
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign m_address = lat_addr;
    assign m_wdata   = lat_wdata;
    assign m_sel     = lat_sel;
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

endmodule
